// File: rtl/apb_master.sv
// APB master bridge: one host command at a time in, one APB transfer out,
// one response back, with an optional ACCESS-phase wait timeout.
module apb_master #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        pclk,
    input  logic        presetn,

    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [11:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_strb,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_slverr,
    output logic        rsp_timeout,

    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [11:0] paddr,
    output logic [31:0] pwdata,
    output logic [3:0]  pstrb,
    input  logic        pready,
    input  logic        pslverr,
    input  logic [31:0] prdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam bit         TMO_EN    = (TIMEOUT != 0);
    localparam logic [7:0] WAIT_LAST = TMO_EN ? 8'(TIMEOUT - 1) : 8'd0;

    state_t     state;
    logic [7:0] wait_cnt;
    logic       timeout_hit;

    // The abort fires on the ACCESS cycle whose count equals TIMEOUT-1, i.e.
    // after exactly TIMEOUT ACCESS cycles with pready low.
    assign timeout_hit = TMO_EN && (wait_cnt == WAIT_LAST);

    // NOTE: all state and registered outputs use non-blocking assignments and
    // an asynchronous reset, so every output is a flop with a defined value
    // the instant presetn falls.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state       <= IDLE;
            wait_cnt    <= 8'd0;
            cmd_ready   <= 1'b1;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= 12'd0;
            pwdata      <= 32'd0;
            pstrb       <= 4'd0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= 32'd0;
            rsp_slverr  <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        state     <= SETUP;
                        cmd_ready <= 1'b0;
                        psel      <= 1'b1;
                        pwrite    <= cmd_write;
                        paddr     <= cmd_addr;
                        pwdata    <= cmd_wdata;
                        // Reads never present byte strobes to the completer.
                        pstrb     <= cmd_write ? cmd_strb : 4'd0;
                    end
                end

                SETUP: begin
                    state    <= ACCESS;
                    penable  <= 1'b1;
                    wait_cnt <= 8'd0;
                end

                ACCESS: begin
                    if (pready) begin
                        state       <= RESP;
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= pwrite ? 32'd0 : prdata;
                        rsp_slverr  <= pslverr;
                        rsp_timeout <= 1'b0;
                    end else if (timeout_hit) begin
                        state       <= RESP;
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= 32'd0;
                        rsp_slverr  <= 1'b1;
                        rsp_timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end

                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: directed vector table, randomized
// transfers against an outcome model, and a mid-ACCESS reset sequence.
module tb_apb_master;

    localparam int TMO = 4;

    logic        pclk;
    logic        presetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [11:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_strb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_slverr;
    logic        rsp_timeout;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [11:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        pready;
    logic        pslverr;
    logic [31:0] prdata;

    apb_master #(.TIMEOUT(TMO)) dut (
        .pclk        (pclk),
        .presetn     (presetn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_strb    (cmd_strb),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_slverr  (rsp_slverr),
        .rsp_timeout (rsp_timeout),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .paddr       (paddr),
        .pwdata      (pwdata),
        .pstrb       (pstrb),
        .pready      (pready),
        .pslverr     (pslverr),
        .prdata      (prdata)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    typedef struct {
        logic        write;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          waits;
        logic [31:0] prdata;
        logic        slverr;
        int          rsp_delay;
        int          exp_access;
        logic [31:0] exp_rdata;
        logic        exp_slverr;
        logic        exp_timeout;
    } vec_t;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Outcome of one transfer from the completer's wait count alone: the
    // transfer either completes after waits+1 ACCESS cycles, or is abandoned
    // after TMO ACCESS cycles if the completer would still be stalling.
    function automatic vec_t model(input vec_t v);
        vec_t r;
        r = v;
        if (TMO != 0 && v.waits >= TMO) begin
            r.exp_access  = TMO;
            r.exp_rdata   = 32'd0;
            r.exp_slverr  = 1'b1;
            r.exp_timeout = 1'b1;
        end else begin
            r.exp_access  = v.waits + 1;
            r.exp_rdata   = v.write ? 32'd0 : v.prdata;
            r.exp_slverr  = v.slverr;
            r.exp_timeout = 1'b0;
        end
        return r;
    endfunction

    task automatic run_txn(input vec_t v);
        int          acc;
        int          budget;
        logic [3:0]  exp_strb;
        exp_strb = v.write ? v.strb : 4'h0;

        budget = 0;
        while (cmd_ready !== 1'b1 && budget < 20) begin
            @(negedge pclk);
            budget++;
        end
        check("idle cmd_ready", 32'(cmd_ready), 32'd1);
        if (cmd_ready !== 1'b1) return;

        cmd_valid = 1'b1;
        cmd_write = v.write;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        cmd_strb  = v.strb;
        @(negedge pclk);
        // Scramble the command bus: the in-flight transfer must not notice.
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom);
        cmd_addr  = 12'($urandom);
        cmd_wdata = $urandom;
        cmd_strb  = 4'($urandom);

        check("setup psel",      32'(psel),      32'd1);
        check("setup penable",   32'(penable),   32'd0);
        check("setup cmd_ready", 32'(cmd_ready), 32'd0);
        check("setup pwrite",    32'(pwrite),    32'(v.write));
        check("setup paddr",     32'(paddr),     32'(v.addr));
        check("setup pwdata",    pwdata,         v.wdata);
        check("setup pstrb",     32'(pstrb),     32'(exp_strb));

        acc = 0;
        @(negedge pclk);
        while (psel === 1'b1 && penable === 1'b1 && acc < 300) begin
            acc++;
            check("access paddr",  32'(paddr),  32'(v.addr));
            check("access pwdata", pwdata,      v.wdata);
            check("access pstrb",  32'(pstrb),  32'(exp_strb));
            check("access cmd_ready", 32'(cmd_ready), 32'd0);
            pready = (acc - 1 == v.waits);
            // pslverr/prdata are noise until pready is high.
            prdata  = pready ? v.prdata : $urandom;
            pslverr = pready ? v.slverr : 1'($urandom);
            @(negedge pclk);
        end
        pready  = 1'b0;
        pslverr = 1'b0;

        check("access cycles", 32'(acc), 32'(v.exp_access));
        check("resp rsp_valid",   32'(rsp_valid),   32'd1);
        check("resp psel",        32'(psel),        32'd0);
        check("resp penable",     32'(penable),     32'd0);
        check("resp rsp_rdata",   rsp_rdata,        v.exp_rdata);
        check("resp rsp_slverr",  32'(rsp_slverr),  32'(v.exp_slverr));
        check("resp rsp_timeout", 32'(rsp_timeout), 32'(v.exp_timeout));

        for (int i = 0; i < v.rsp_delay; i++) begin
            cmd_valid = 1'b1;
            cmd_write = 1'($urandom);
            cmd_addr  = 12'($urandom);
            cmd_wdata = $urandom;
            cmd_strb  = 4'($urandom);
            @(negedge pclk);
            check("hold rsp_valid",   32'(rsp_valid),   32'd1);
            check("hold rsp_rdata",   rsp_rdata,        v.exp_rdata);
            check("hold rsp_slverr",  32'(rsp_slverr),  32'(v.exp_slverr));
            check("hold rsp_timeout", 32'(rsp_timeout), 32'(v.exp_timeout));
            check("hold cmd_ready",   32'(cmd_ready),   32'd0);
            check("hold psel",        32'(psel),        32'd0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge pclk);
        rsp_ready = 1'b0;
        check("done rsp_valid", 32'(rsp_valid), 32'd0);
        check("done cmd_ready", 32'(cmd_ready), 32'd1);
        check("done psel",      32'(psel),      32'd0);
    endtask

    vec_t dir_vecs[6];
    vec_t rv;

    initial begin
        //              wr    addr    wdata         strb  waits prdata        slv   dly  acc rdata         slv   tmo
        dir_vecs[0] = '{1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 0,  32'h0,        1'b0, 0,   1,  32'h0,        1'b0, 1'b0};
        dir_vecs[1] = '{1'b0, 12'h004, 32'h0,        4'hF, 3,  32'h12345678, 1'b0, 1,   4,  32'h12345678, 1'b0, 1'b0};
        dir_vecs[2] = '{1'b0, 12'h008, 32'h0,        4'h3, 1,  32'hCAFEF00D, 1'b1, 0,   2,  32'hCAFEF00D, 1'b1, 1'b0};
        dir_vecs[3] = '{1'b0, 12'h0FC, 32'h0,        4'h0, 50, 32'h55AA55AA, 1'b0, 2,   4,  32'h0,        1'b1, 1'b1};
        dir_vecs[4] = '{1'b1, 12'hFFC, 32'hA5A5A5A5, 4'h6, 2,  32'h11111111, 1'b1, 5,   3,  32'h0,        1'b1, 1'b0};
        dir_vecs[5] = '{1'b1, 12'h800, 32'h01234567, 4'h9, 4,  32'h0,        1'b0, 0,   4,  32'h0,        1'b1, 1'b1};

        presetn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 12'd0;
        cmd_wdata = 32'd0;
        cmd_strb  = 4'd0;
        rsp_ready = 1'b0;
        pready    = 1'b0;
        pslverr   = 1'b0;
        prdata    = 32'd0;

        #12;
        check("rst psel",        32'(psel),        32'd0);
        check("rst penable",     32'(penable),     32'd0);
        check("rst pwrite",      32'(pwrite),      32'd0);
        check("rst paddr",       32'(paddr),       32'd0);
        check("rst pwdata",      pwdata,           32'd0);
        check("rst pstrb",       32'(pstrb),       32'd0);
        check("rst rsp_valid",   32'(rsp_valid),   32'd0);
        check("rst rsp_rdata",   rsp_rdata,        32'd0);
        check("rst rsp_slverr",  32'(rsp_slverr),  32'd0);
        check("rst rsp_timeout", 32'(rsp_timeout), 32'd0);
        @(negedge pclk);
        presetn = 1'b1;
        @(negedge pclk);
        check("rst cmd_ready", 32'(cmd_ready), 32'd1);

        // Wait count 3 reaches the timeout cycle with pready high: completes.
        for (int i = 0; i < 6; i++) run_txn(dir_vecs[i]);

        for (int i = 0; i < 25; i++) begin
            rv.write     = 1'($urandom);
            rv.addr      = 12'($urandom);
            rv.wdata     = $urandom;
            rv.strb      = 4'($urandom);
            rv.waits     = int'($urandom_range(0, 6));
            rv.prdata    = $urandom;
            rv.slverr    = 1'($urandom);
            rv.rsp_delay = int'($urandom_range(0, 3));
            run_txn(model(rv));
        end

        // Reset in the middle of a stalled ACCESS phase.
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 12'h044;
        @(negedge pclk);
        cmd_valid = 1'b0;
        @(negedge pclk);
        check("pre-rst penable", 32'(penable), 32'd1);
        @(negedge pclk);
        #2 presetn = 1'b0;
        #1;
        check("midrst psel",      32'(psel),      32'd0);
        check("midrst penable",   32'(penable),   32'd0);
        check("midrst rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst cmd_ready", 32'(cmd_ready), 32'd1);
        check("midrst paddr",     32'(paddr),     32'd0);
        @(negedge pclk);
        presetn = 1'b1;
        @(negedge pclk);
        check("post-rst rsp_valid", 32'(rsp_valid), 32'd0);
        run_txn(dir_vecs[0]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
